johnson_seq_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit Johnson ring. It generates 2*WIDTH-phase enable patterns: direction, step count and step rate are programmable, and start/stop is controlled by the host. It sits between a host/control FSM and the multiphase consumers (phase enables, stepper drivers), and it supplies both true and complemented phase outputs. It also checks every cycle for illegal ring codes and recovers the ring to all-zeros when one is found.

---
 rtl/johnson_pkg.sv | 18 +
 rtl/johnson_ring_core.sv | 22 ++
 rtl/johnson_seq_ctrl.sv | 82 ++++++++
 tb/tb_johnson_seq_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg: shared state encoding, direction constants and ring-code legality check
package johnson_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
  // A Johnson code has at most one boundary between adjacent bits; w is the live ring width.
  function automatic logic is_legal_johnson(input logic [31:0] q, input int w);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++)
      if (i < w - 1 && q[i] != q[i+1]) n++;
    return n <= 1;
  endfunction
endpackage

// File: rtl/johnson_ring_core.sv
// johnson_ring_core: Johnson ring register with forward/reverse stepping
//   clk, rst (async, active-high) | step_en: advance one phase | dir: DIR_FWD/DIR_REV
//   clear: synchronous return to all-zeros (wins over step) | q: ring state | q_bar: ~q
module johnson_ring_core
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clear) q <= '0;
    else if (step_en) q <= (dir == DIR_REV) ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
  assign q_bar = ~q;
endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: programmable Johnson-ring sequencer with illegal-code recovery
//   clk, rst (async, active-high) | start, stop: host control | dir, step_count, div: latched at start
//   q, q_bar: ring phases | busy: in RUN | done: one-cycle completion pulse | err: sticky illegal-code flag
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [CNT_W-1:0] step_count,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t           state;
  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] div_l;
  logic [CNT_W-1:0] rem;
  logic             dir_l;
  logic             legal;
  logic             step_en;
  assign legal   = is_legal_johnson(32'(q), WIDTH);
  // stop and an illegal code both suppress the step due this edge
  assign step_en = legal && state == RUN && !stop && pre == '0;
  johnson_ring_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .step_en(step_en), .dir(dir_l), .clear(!legal), .q(q), .q_bar(q_bar)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      div_l <= '0;
      rem   <= '0;
      dir_l <= DIR_FWD;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else if (!legal) begin
      state <= FAULT;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        if (stop) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (pre == '0) begin
          pre <= div_l;
          rem <= rem - 1'b1;
          if (rem == 1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else pre <= pre - 1'b1;
      end else if (start && !stop) begin
        dir_l <= dir;
        div_l <= div;
        pre   <= div;
        err   <= 1'b0;
        if (step_count == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
          rem   <= step_count;
        end
      end
    end
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: directed self-checking bench for johnson_seq_ctrl
module tb_johnson_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] step_count = '0;
  logic [3:0] div = '0;
  logic [3:0] q, q_bar;
  logic       busy, done, err;
  int         total = 0;
  int         bad = 0;
  johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .step_count(step_count),
    .div(div), .q(q), .q_bar(q_bar), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic d, input logic [3:0] dv, input logic [7:0] sc);
    dir = d;
    div = dv;
    step_count = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic expect_q(input string tag, input logic [3:0] eq, input logic eb, input logic ed);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_busy"}, busy, eb);
    chk({tag, "_done"}, done, ed);
  endtask
  initial begin
    #2;
    expect_q("rst", 4'b0000, 0, 0);
    chk("rst_qbar", q_bar, 4'b1111);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    // forward 5 steps, div=0
    go(0, 0, 5);
    expect_q("f_start", 4'b0000, 1, 0);
    tick(); expect_q("f1", 4'b1000, 1, 0);
    tick(); expect_q("f2", 4'b1100, 1, 0);
    tick(); expect_q("f3", 4'b1110, 1, 0);
    tick(); expect_q("f4", 4'b1111, 1, 0);
    tick(); expect_q("f5", 4'b0111, 0, 1);
    tick(); expect_q("f_end", 4'b0111, 0, 0);
    chk("f_qbar", q_bar, 4'b1000);
    // reverse 3 steps, then zero-count start
    go(1, 0, 3);
    expect_q("r_start", 4'b0111, 1, 0);
    tick(); expect_q("r1", 4'b1111, 1, 0);
    tick(); expect_q("r2", 4'b1110, 1, 0);
    tick(); expect_q("r3", 4'b1100, 0, 1);
    tick(); expect_q("r_end", 4'b1100, 0, 0);
    go(0, 0, 0);
    expect_q("z_done", 4'b1100, 0, 1);
    tick(); expect_q("z_end", 4'b1100, 0, 0);
    // back to 0000, then div=2 forward
    go(1, 0, 2);
    tick(); tick(); expect_q("back0", 4'b0000, 0, 1);
    go(0, 2, 2);
    expect_q("d0", 4'b0000, 1, 0);
    tick(); expect_q("d1", 4'b0000, 1, 0);
    tick(); expect_q("d2", 4'b0000, 1, 0);
    tick(); expect_q("d3", 4'b1000, 1, 0);
    tick(); expect_q("d4", 4'b1000, 1, 0);
    tick(); expect_q("d5", 4'b1000, 1, 0);
    tick(); expect_q("d6", 4'b1100, 0, 1);
    tick();
    // back to 0000, then div=3 run aborted by stop; start mid-run ignored
    go(1, 0, 2);
    tick(); tick(); expect_q("back1", 4'b0000, 0, 1);
    go(0, 3, 8);
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) begin
        dir = 1'b1;
        div = 4'd0;
        step_count = 8'd1;
        start = 1'b1;
      end
      tick();
      chk($sformatf("s%0d_q", i), q, i < 4 ? 4'b0000 : i < 8 ? 4'b1000 : 4'b1100);
      chk($sformatf("s%0d_busy", i), busy, 1);
      chk($sformatf("s%0d_done", i), done, 0);
    end
    start = 1'b0;
    stop = 1'b1;
    tick(); expect_q("stop", 4'b1100, 0, 0);
    stop = 1'b0;
    tick(); expect_q("stop_hold", 4'b1100, 0, 0);
    // start and stop together in IDLE: nothing starts
    start = 1'b1;
    stop = 1'b1;
    step_count = 8'd3;
    tick();
    start = 1'b0;
    stop = 1'b0;
    expect_q("ss", 4'b1100, 0, 0);
    tick(); expect_q("ss2", 4'b1100, 0, 0);
    // illegal code deposited during RUN
    go(0, 3, 8);
    chk("ill_busy0", busy, 1);
    force dut.u_core.q = 4'b0101;
    #1;
    release dut.u_core.q;
    tick();
    expect_q("ill", 4'b0000, 0, 0);
    chk("ill_err", err, 1);
    tick(); tick();
    expect_q("ill_hold", 4'b0000, 0, 0);
    chk("ill_err_sticky", err, 1);
    go(0, 0, 1);
    chk("rec_err", err, 0);
    chk("rec_busy", busy, 1);
    tick(); expect_q("rec", 4'b1000, 0, 1);
    tick();
    // async reset mid-run
    go(0, 1, 8);
    tick(); tick();
    chk("ar_pre_q", q, 4'b1100);
    #2 rst = 1'b1;
    #1;
    expect_q("ar", 4'b0000, 0, 0);
    chk("ar_err", err, 0);
    chk("ar_qbar", q_bar, 4'b1111);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_q($sformatf("ar_after%0d", i), 4'b0000, 0, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
